// File: rtl/fp_int_acc.sv
// fp_int_acc: aligns fp16 x int partial products into a wide signed fixed-point sum, emits fp32 at end of run.
// Latency: last product sampled at E0, sum final at E1, result/result_valid registered at E2.
// Backpressure: none; products arriving while busy (FLUSH/NORM) are dropped and flagged on drop_err.
// Optional: define FP_INT_ACC_ROUND_RNE_EN for round-to-nearest-even conversion (default truncates).
module fp_int_acc #(
   parameter int ACC_WIDTH = 48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sign_in,
   input  logic [4:0]  exp_in,
   input  logic [13:0] mantissa_in,
   input  logic        start_acc,
   input  logic        last,
   input  logic        clear,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy,
   output logic        overflow,
   output logic        drop_err
);

   localparam int PW = $clog2(ACC_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FLUSH = 2'd2,
      S_NORM  = 2'd3
   } state_t;

   state_t                r_state;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic [ACC_WIDTH-1:0]  r_term;
   logic                  r_term_vld;
   logic [31:0]           r_result;
   logic                  r_result_valid;
   logic                  r_overflow;
   logic                  r_drop_err;

   logic                  w_busy;
   logic                  w_accept;
   logic [ACC_WIDTH-1:0]  w_shift;
   logic [ACC_WIDTH-1:0]  w_term;
   logic [ACC_WIDTH-1:0]  w_sum;
   logic                  w_add_ovf;
   logic [ACC_WIDTH-2:0]  w_low;
   logic [ACC_WIDTH-2:0]  w_mag;
   logic [ACC_WIDTH-2:0]  w_norm;
   logic [PW-1:0]         w_p;
   logic [7:0]            w_exp;
   logic [22:0]           w_frac;
   logic [31:0]           w_fp32;
`ifdef FP_INT_ACC_ROUND_RNE_EN
   logic                  w_guard;
   logic                  w_sticky;
   logic                  w_carry;
`endif

   assign w_busy   = (r_state == S_FLUSH) || (r_state == S_NORM);
   assign w_accept = start_acc && !w_busy;

   // The accumulator keeps its top bit as sign, so a shift of up to 31 on a 14-bit mantissa still fits.
   assign w_sum     = r_acc + r_term;
   assign w_add_ovf = (r_acc[ACC_WIDTH-1] == r_term[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

   // Align the incoming product to the 2^-25 LSB grid; exponent 0 flushes to zero.
   always_comb begin
      w_shift = {{(ACC_WIDTH-14){1'b0}}, mantissa_in} << exp_in;
      w_term  = '0;
      if (exp_in != 5'd0) begin
         w_term = sign_in ? -w_shift : w_shift;
      end
   end

   // Sign-magnitude split, leading-one search and fp32 packing of the running sum.
   always_comb begin
      w_low = r_acc[ACC_WIDTH-2:0];
      w_mag = r_acc[ACC_WIDTH-1] ? -w_low : w_low;
      w_p   = '0;
      for (int i = 0; i < ACC_WIDTH-1; i++) begin
         if (w_mag[i]) begin
            w_p = i[PW-1:0];
         end
      end
      // Move the leading one up to the top bit so the fraction sits at a fixed position.
      w_norm = w_mag << (PW'(ACC_WIDTH-2) - w_p);
      w_exp  = 8'(w_p) + 8'd102;
      w_frac = 23'(w_norm >> (ACC_WIDTH-25));
`ifdef FP_INT_ACC_ROUND_RNE_EN
      w_guard  = w_norm[ACC_WIDTH-26];
      w_sticky = |w_norm[ACC_WIDTH-27:0];
      w_carry  = 1'b0;
      if (w_guard && (w_sticky || w_frac[0])) begin
         {w_carry, w_frac} = {1'b0, w_frac} + 24'd1;
         if (w_carry) begin
            w_exp = w_exp + 8'd1;
         end
      end
`endif
      w_fp32 = (w_mag == '0) ? 32'h0000_0000 : {r_acc[ACC_WIDTH-1], w_exp, w_frac};
   end

   // Run control, term pipeline register, accumulator and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_acc          <= '0;
         r_term         <= '0;
         r_term_vld     <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_overflow     <= 1'b0;
         r_drop_err     <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (clear) begin
            r_acc      <= '0;
            r_term_vld <= 1'b0;
            r_state    <= S_IDLE;
            r_overflow <= 1'b0;
            r_drop_err <= 1'b0;
         end else begin
            r_term_vld <= w_accept;
            if (w_accept) begin
               r_term <= w_term;
            end
            if (start_acc && w_busy) begin
               r_drop_err <= 1'b1;
            end
            if (r_term_vld) begin
               r_acc <= w_sum;
               if (w_add_ovf) begin
                  r_overflow <= 1'b1;
               end
            end
            case (r_state)
               S_IDLE: begin
                  if (start_acc) begin
                     r_state <= last ? S_FLUSH : S_ACCUM;
                  end
               end
               S_ACCUM: begin
                  if (start_acc && last) begin
                     r_state <= S_FLUSH;
                  end
               end
               S_FLUSH: begin
                  r_state <= S_NORM;
               end
               S_NORM: begin
                  r_result       <= w_fp32;
                  r_result_valid <= 1'b1;
                  r_acc          <= '0;
                  r_term_vld     <= 1'b0;
                  r_overflow     <= 1'b0;
                  r_state        <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign busy         = w_busy;
   assign overflow     = r_overflow;
   assign drop_err     = r_drop_err;

endmodule

// File: tb/tb_fp_int_acc.sv
// tb_fp_int_acc: randomized and directed runs of fp_int_acc against an arithmetic reference model.
// Latency: checks result two edges after the last product.
// Backpressure: exercises dropped products while busy and synchronous clear.
module tb_fp_int_acc;

   localparam int W = 48;

   logic        clk = 1'b0;
   logic        rst;
   logic        sign_in;
   logic [4:0]  exp_in;
   logic [13:0] mantissa_in;
   logic        start_acc;
   logic        last;
   logic        clear;
   logic [31:0] result;
   logic        result_valid;
   logic        busy;
   logic        overflow;
   logic        drop_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   longint      mdl_sum = 0;
   bit          mdl_ovf = 1'b0;
   logic [31:0] res;
   logic [31:0] held;

   fp_int_acc #(.ACC_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .sign_in      (sign_in),
      .exp_in       (exp_in),
      .mantissa_in  (mantissa_in),
      .start_acc    (start_acc),
      .last         (last),
      .clear        (clear),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .overflow     (overflow),
      .drop_err     (drop_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint wrap_acc(input longint v);
      return (v <<< (64-W)) >>> (64-W);
   endfunction

   // Reference fp32 value of a signed sum expressed in units of 2^-25.
   function automatic logic [31:0] ref_fp32(input longint s);
      longint mag;
      longint frac;
      longint rem;
      longint half;
      int     p;
      int     e;
      mag = (s < 0) ? -s : s;
      mag = mag & ((longint'(1) << (W-1)) - 1);
      if (mag == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < W-1; i++) if (((mag >> i) & 1) == 1) p = i;
      e = p + 102;
      if (p >= 23) begin
         frac = mag >> (p-23);
         rem  = mag - (frac << (p-23));
      end else begin
         frac = mag << (23-p);
         rem  = 0;
      end
`ifdef FP_INT_ACC_ROUND_RNE_EN
      if (p > 23) begin
         half = longint'(1) << (p-24);
         if (rem > half || (rem == half && (frac & 1) == 1)) frac = frac + 1;
      end
      if (frac >= (longint'(1) << 24)) begin
         frac = frac >> 1;
         e    = e + 1;
      end
`else
      half = rem;
`endif
      return {(s < 0) ? 1'b1 : 1'b0, 8'(e), 23'(frac)};
   endfunction

   task automatic mdl_add(input bit s, input logic [4:0] e, input logic [13:0] m);
      longint t;
      longint raw;
      t = (e == 5'd0) ? 0 : (longint'(m) << e);
      if (s) t = -t;
      raw = mdl_sum + t;
      if (raw > ((longint'(1) << (W-1)) - 1) || raw < -(longint'(1) << (W-1))) mdl_ovf = 1'b1;
      mdl_sum = wrap_acc(raw);
   endtask

   task automatic mdl_reset();
      mdl_sum = 0;
      mdl_ovf = 1'b0;
   endtask

   // Called just after a falling edge; presents one product for one rising edge.
   task automatic send(input bit s, input logic [4:0] e, input logic [13:0] m, input bit l);
      sign_in     = s;
      exp_in      = e;
      mantissa_in = m;
      last        = l;
      start_acc   = 1'b1;
      @(negedge clk);
      start_acc   = 1'b0;
      last        = 1'b0;
      mdl_add(s, e, m);
   endtask

   // Waits for the result of a run whose last product was just sent.
   task automatic finish_run(input string tag, output logic [31:0] r);
      int          cnt;
      logic        ovf_s;
      logic [31:0] exp_r;
      bit          exp_o;
      cnt   = 0;
      ovf_s = 1'b0;
      exp_r = ref_fp32(mdl_sum);
      exp_o = mdl_ovf;
      check({tag, " busy"}, 64'(busy), 64'd1);
      while (cnt < 8) begin
         @(negedge clk);
         cnt++;
         if (result_valid) break;
         ovf_s = overflow;
      end
      check({tag, " latency"}, 64'(cnt), 64'd2);
      check({tag, " result"}, 64'(result), 64'(exp_r));
      check({tag, " overflow"}, 64'(ovf_s), 64'(exp_o));
      r = result;
      @(negedge clk);
      check({tag, " pulse"}, 64'(result_valid), 64'd0);
      check({tag, " ovf_clr"}, 64'(overflow), 64'd0);
      mdl_reset();
   endtask

   initial begin
      rst = 1'b1; sign_in = 1'b0; exp_in = '0; mantissa_in = '0;
      start_acc = 1'b0; last = 1'b0; clear = 1'b0;
      repeat (2) @(negedge clk);
      check("rst result", 64'(result), 64'd0);
      check("rst valid", 64'(result_valid), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst overflow", 64'(overflow), 64'd0);
      check("rst drop_err", 64'(drop_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      send(1'b0, 5'd15, 14'h0400, 1'b1);
      finish_run("one", res);
      check("one const", 64'(res), 64'h3F80_0000);

      send(1'b0, 5'd15, 14'h0400, 1'b0);
      send(1'b1, 5'd15, 14'h0400, 1'b1);
      finish_run("cancel", res);
      check("cancel const", 64'(res), 64'h0);

      for (int k = 0; k < 4; k++) send(1'b0, 5'd15, 14'h0400, k == 3);
      finish_run("four", res);
      check("four const", 64'(res), 64'h4080_0000);

      send(1'b0, 5'd16, 14'h0C00, 1'b1);
      finish_run("six", res);
      check("six const", 64'(res), 64'h40C0_0000);

      send(1'b0, 5'd30, 14'h0400, 1'b0);
      send(1'b0, 5'd7, 14'h0600, 1'b1);
      finish_run("ulp", res);
`ifdef FP_INT_ACC_ROUND_RNE_EN
      check("ulp const", 64'(res), 64'h4700_0002);
`else
      check("ulp const", 64'(res), 64'h4700_0001);
`endif

      send(1'b0, 5'd0, 14'h3FFF, 1'b1);
      finish_run("ftz", res);
      check("ftz const", 64'(res), 64'h0);

      // Product offered during FLUSH must be ignored.
      send(1'b0, 5'd15, 14'h0400, 1'b1);
      sign_in = 1'b0; exp_in = 5'd20; mantissa_in = 14'h0400; start_acc = 1'b1;
      @(negedge clk);
      start_acc = 1'b0;
      check("drop flag", 64'(drop_err), 64'd1);
      @(negedge clk);
      check("drop valid", 64'(result_valid), 64'd1);
      check("drop result", 64'(result), 64'h3F80_0000);
      mdl_reset();
      @(negedge clk);
      check("drop sticky", 64'(drop_err), 64'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear drop", 64'(drop_err), 64'd0);
      check("clear busy", 64'(busy), 64'd0);

      // Clear mid-run: no result, held value kept, next run clean.
      held = result;
      send(1'b0, 5'd20, 14'h0123, 1'b0);
      send(1'b1, 5'd18, 14'h0456, 1'b0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      mdl_reset();
      repeat (3) begin
         @(negedge clk);
         check("clear novalid", 64'(result_valid), 64'd0);
      end
      check("clear hold", 64'(result), 64'(held));
      send(1'b1, 5'd17, 14'h0700, 1'b1);
      finish_run("after clear", res);

      // Reset mid-run discards the partial sum.
      send(1'b0, 5'd15, 14'h0400, 1'b0);
      send(1'b0, 5'd15, 14'h0400, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst result", 64'(result), 64'd0);
      rst = 1'b0;
      mdl_reset();
      @(negedge clk);
      send(1'b0, 5'd15, 14'h0400, 1'b1);
      finish_run("midrst", res);
      check("midrst const", 64'(res), 64'h3F80_0000);

      for (int r = 0; r < 60; r++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            bit          s;
            logic [4:0]  e;
            logic [13:0] m;
            s = 1'($urandom_range(0, 1));
            e = (r % 3 == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 31));
            m = 14'($urandom);
            send(s, e, m, k == n-1);
            if (k < n-1) repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         finish_run("rand", res);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_int_acc.md
Name: fp_int_acc

Overview:
- Downstream of the fp16 x int bit-serial multiplier.
- Consumes each finished partial product (sign, 5-bit fp16 exponent, 14-bit 4.10 fixed mantissa), strobed by the multiplier's start_acc.
- Aligns each product into a wide signed fixed-point accumulator and sums a dot-product run.
- On the last product, normalises the sum to IEEE-754 fp32 for the output/requant stage.

Parameters:
- ACC_WIDTH, 48, signed accumulator width; LSB weight 2^-25; minimum legal value 46.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sign_in  in  1  product sign (1 = negative)
- exp_in  in  5  fp16 biased exponent of product
- mantissa_in  in  14  product magnitude, 4 integer bits . 10 fraction bits
- start_acc  in  1  product valid strobe; sample sign/exp/mantissa this cycle
- last  in  1  qualifies start_acc: this product ends the run
- clear  in  1  synchronous abort/clear
- result  out  32  fp32 sum
- result_valid  out  1  one-cycle pulse, result valid
- busy  out  1  high in FLUSH/NORM; products not accepted
- overflow  out  1  sticky: accumulator wrapped during the current run
- drop_err  out  1  sticky: start_acc arrived while busy

Behaviour:
- Reset (rst=1, async): state=IDLE, acc=0, term=0, result=0, result_valid=0, overflow=0, drop_err=0.
- Product value = (-1)^sign * mantissa_in * 2^(exp_in-25).
- Alignment term = mantissa_in << exp_in, zero-extended to ACC_WIDTH, then negated (two's complement) if sign_in.
- exp_in==0 (fp16 subnormal/zero): term=0, flush-to-zero.
- exp_in==31 is treated as a normal shift of 31; no inf/NaN handling.
- Stage A: on an edge with start_acc=1 and state in {IDLE, ACCUM}, register the term into term_reg and set term_vld.
- Stage B: on each edge with term_vld=1, acc <= acc + term_reg, wrapping modulo 2^ACC_WIDTH.
  - Signed overflow sets overflow.
- States:
  - IDLE: no run open.
    - start_acc & !last -> ACCUM.
    - start_acc & last -> FLUSH.
  - ACCUM: start_acc & last -> FLUSH; otherwise stay.
    - Gaps (start_acc=0) are allowed indefinitely.
  - FLUSH: the final term is added this edge -> NORM.
  - NORM: fp32 conversion of acc is registered into result; result_valid<=1.
    - Same edge: acc<=0, term_vld<=0, overflow<=0, state -> IDLE.
- Latency: the edge sampling the last product is E0. acc is final at E1. result/result_valid appear after E2.
- A new run may start on the cycle after result_valid (state IDLE).
- Conversion:
  - M = |acc| (ACC_WIDTH-1 bits).
  - p = index of the leading one of M.
  - fp32 exponent = p + 102; sign = acc MSB.
  - fraction = the 23 bits below p, zero-padded when p<23.
  - Bits below that are truncated (round toward zero).
  - M==0 -> 0x00000000 (positive zero, even if acc was negated).
- result holds its value until the next NORM. result_valid is high for exactly one cycle.
- start_acc while busy: the product is ignored and drop_err<=1. drop_err is cleared only by rst or clear.
- clear=1 (synchronous, priority over start_acc):
  - acc=0, term_vld=0, state=IDLE, overflow=0, drop_err=0.
  - No result_valid; result is unchanged.
- rst mid-run: everything returns to reset values immediately; the partial sum is lost.
- Simultaneous start_acc and stage-B add in ACCUM is normal pipelined operation: the new term is registered while the old term is added.

Optional Feature:
- Macro FP_INT_ACC_ROUND_RNE_EN.
- Defined:
  - Conversion rounds to nearest-even using guard bit plus OR-reduced sticky bits below it.
  - Mantissa carry-out increments the exponent.
  - Conversion remains one cycle.
- Undefined: truncation as described in Behaviour.

Test Plan:
- Single product sign=0, exp=15, mant=0x0400, last=1 -> result_valid two edges after E0, result=0x3F800000.
- Products (0,15,0x0400) then (1,15,0x0400, last) -> result=0x00000000, overflow=0.
- Four back-to-back products (0,15,0x0400), last on the 4th -> 0x40800000. Single product (0,16,0x0C00,last) -> 0x40C00000.
- Products (0,30,0x0400) then (0,7,0x0600,last), i.e. 32768 + 1.5 ulp:
  - Truncate build -> 0x47000001.
  - FP_INT_ACC_ROUND_RNE_EN build -> 0x47000002.
- start_acc pulsed on the FLUSH cycle -> product dropped, drop_err=1, result excludes it. Then clear=1 -> drop_err=0, state IDLE.
- Assert rst after 2 of 4 products, release, send (0,15,0x0400,last) -> result=0x3F800000, no stale sum.
